gcd_host_driver: RTL

//  Requester-side driver for the GCD datapath/controller engine. Accepts an operand

---
 rtl/gcd_host_driver.sv | 96 +++++++++
 1 files changed

// File: rtl/gcd_host_driver.sv
// gcd_host_driver: serial-load requester for the GCD engine with valid/ready request and response ports.
// Optional WAIT watchdog enabled by defining GCD_DRV_TIMEOUT_EN.
module gcd_host_driver #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] gcd_data_in,
    output logic             gcd_start,
    input  logic             gcd_done,
    input  logic [WIDTH-1:0] gcd_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_gcd,
    output logic             rsp_err,
    output logic             busy
);
    localparam logic [2:0] IDLE = 3'd0, LOAD_A = 3'd1, LOAD_B = 3'd2, WAIT = 3'd3, RESP = 3'd4;
    logic [2:0]       state;
    logic [WIDTH-1:0] b_reg;
`ifdef GCD_DRV_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
`endif
    assign req_ready = state == IDLE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            b_reg       <= '0;
            gcd_data_in <= '0;
            gcd_start   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_gcd     <= '0;
            rsp_err     <= 1'b0;
            busy        <= 1'b0;
`ifdef GCD_DRV_TIMEOUT_EN
            cnt         <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    b_reg <= req_b;
                    busy  <= 1'b1;
                    // A zero operand would never let the engine finish, so answer directly
                    if (req_a != '0 && req_b != '0) begin
                        state       <= LOAD_A;
                        gcd_data_in <= req_a;
                        gcd_start   <= 1'b1;
                    end else begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_gcd   <= req_a | req_b;
                        rsp_err   <= req_a == '0 && req_b == '0;
                    end
                end
                LOAD_A: begin
                    state       <= LOAD_B;
                    gcd_data_in <= b_reg;
                end
                LOAD_B: begin
                    state <= WAIT;
`ifdef GCD_DRV_TIMEOUT_EN
                    cnt   <= '0;
`endif
                end
                WAIT: if (gcd_done) begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_gcd   <= gcd_result;
                    rsp_err   <= 1'b0;
                    gcd_start <= 1'b0;
                end
`ifdef GCD_DRV_TIMEOUT_EN
                else if (cnt == CW'(TIMEOUT - 1)) begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_gcd   <= '0;
                    rsp_err   <= 1'b1;
                    gcd_start <= 1'b0;
                end else cnt <= cnt + 1'b1;
`endif
                RESP: if (rsp_ready) begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
